// File: rtl/mm_pkg.sv
// mm_pkg: shared state encoding and sizing helpers for the matmul sequencer
package mm_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int feed_len(input int k, input int n);
    return k + 2 * n - 2;
  endfunction
endpackage

// File: rtl/matmul_array_sequencer_if.sv
// matmul_array_sequencer_if: host command, operand fetch and result drain signals
interface matmul_array_sequencer_if
  import mm_pkg::*;
#(
  parameter int N = 4,
  parameter int K_MAX = 16
);
  localparam int AW = clog2(K_MAX);
  localparam int KW = clog2(K_MAX + 1);
  localparam int RW = clog2(N);
  logic start;
  logic [KW-1:0] k_len;
  logic busy;
  logic err;
  logic clear_acc;
  logic arr_enable;
  logic [N-1:0] a_valid;
  logic [N*AW-1:0] a_addr;
  logic [N-1:0] b_valid;
  logic [N*AW-1:0] b_addr;
  logic result_valid;
  logic [RW-1:0] result_row;
  logic result_ready;
  logic done;
  modport master (
    output start, k_len, result_ready,
    input busy, err, clear_acc, arr_enable, a_valid, a_addr, b_valid, b_addr,
          result_valid, result_row, done
  );
  modport slave (
    input start, k_len, result_ready,
    output busy, err, clear_acc, arr_enable, a_valid, a_addr, b_valid, b_addr,
           result_valid, result_row, done
  );
endinterface

// File: rtl/matmul_skew_gen.sv
// matmul_skew_gen: per-lane skewed operand valid and read address for wavefront step t
module matmul_skew_gen #(
  parameter int N = 4,
  parameter int TW = 5,
  parameter int AW = 4,
  parameter int KW = 5
) (
  input logic [TW-1:0] t,
  input logic [KW-1:0] k_len,
  output logic [N-1:0] valid,
  output logic [N*AW-1:0] addr
);
  logic [TW-1:0] d;
  // lane i lags by i steps; valid while inside its k_len-long window
  always_comb begin
    valid = '0;
    addr = '0;
    d = '0;
    for (int i = 0; i < N; i++) begin
      d = t - TW'(i);
      valid[i] = t >= TW'(i) && d < TW'(k_len);
      addr[i*AW +: AW] = valid[i] ? AW'(d) : '0;
    end
  end
endmodule

// File: rtl/matmul_array_sequencer.sv
// matmul_array_sequencer: sequences clear, skewed operand feed, flush and result drain
module matmul_array_sequencer
  import mm_pkg::*;
#(
  parameter int N = 4,
  parameter int K_MAX = 16
) (
  input logic clk,
  input logic reset,
  matmul_array_sequencer_if.slave bus
);
  localparam int AW = clog2(K_MAX);
  localparam int KW = clog2(K_MAX + 1);
  localparam int TW = clog2(K_MAX + 2 * N);
  localparam int RW = clog2(N);
  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [TW-1:0] t_q, t_d;
  logic [RW-1:0] r_q, r_d;
  logic err_q, err_d;
  logic [N-1:0] av, bv;
  logic [N*AW-1:0] aa, ba;
  logic k_ok, t_last, feed;
  assign k_ok = bus.k_len != '0 && int'(bus.k_len) <= K_MAX;
  assign t_last = int'(t_q) == feed_len(int'(k_q), N) - 1;
  matmul_skew_gen #(.N(N), .TW(TW), .AW(AW), .KW(KW)) u_a (
    .t(t_q), .k_len(k_q), .valid(av), .addr(aa)
  );
  matmul_skew_gen #(.N(N), .TW(TW), .AW(AW), .KW(KW)) u_b (
    .t(t_q), .k_len(k_q), .valid(bv), .addr(ba)
  );
  // state, latched k_len, feed step, drain row and reject pulse
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      k_q <= '0;
      t_q <= '0;
      r_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      t_q <= t_d;
      r_q <= r_d;
      err_q <= err_d;
    end
  // next state; counters return to zero whenever their phase is left
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    t_d = '0;
    r_d = '0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        if (k_ok) begin
          state_d = CLEAR;
          k_d = bus.k_len;
        end else err_d = 1'b1;
      end
      CLEAR: state_d = FEED;
      FEED: begin
        t_d = t_last ? '0 : t_q + 1'b1;
        if (t_last) state_d = FLUSH;
      end
      FLUSH: state_d = DRAIN;
      DRAIN: begin
        r_d = bus.result_ready ? r_q + 1'b1 : r_q;
        if (bus.result_ready && r_q == RW'(N - 1)) begin
          state_d = DONE;
          r_d = '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // outputs depend only on registered state; enable lags feed by the buffer read latency
  always_comb begin
    feed = state_q == FEED;
    bus.busy = state_q != IDLE;
    bus.err = err_q;
    bus.clear_acc = state_q == CLEAR;
    bus.arr_enable = (feed && t_q != '0) || state_q == FLUSH;
    bus.a_valid = feed ? av : '0;
    bus.a_addr = feed ? aa : '0;
    bus.b_valid = feed ? bv : '0;
    bus.b_addr = feed ? ba : '0;
    bus.result_valid = state_q == DRAIN;
    bus.result_row = r_q;
    bus.done = state_q == DONE;
  end
endmodule

// File: tb/tb_matmul_array_sequencer.sv
// tb_matmul_array_sequencer: scoreboard bench for the matmul array sequencer
module tb_matmul_array_sequencer;
  localparam int N = 4;
  localparam int K_MAX = 16;
  localparam int AW = 4;
  localparam int RW = 2;
  typedef struct packed {
    logic busy;
    logic err;
    logic clr;
    logic en;
    logic [N-1:0] av;
    logic [N*AW-1:0] aa;
    logic [N-1:0] bv;
    logic [N*AW-1:0] ba;
    logic rv;
    logic [RW-1:0] row;
    logic done;
  } snap_t;
  typedef struct {
    int cyc;
    snap_t s;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int last_done = -1;
  exp_t q[$];
  matmul_array_sequencer_if #(.N(N), .K_MAX(K_MAX)) bus ();
  matmul_array_sequencer #(.N(N), .K_MAX(K_MAX)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask
  function automatic snap_t cur();
    return {bus.busy, bus.err, bus.clear_acc, bus.arr_enable, bus.a_valid, bus.a_addr,
            bus.b_valid, bus.b_addr, bus.result_valid, bus.result_row, bus.done};
  endfunction
  function automatic snap_t model(input int k, input int s, input int rel);
    snap_t e;
    int f, t, d;
    e = '0;
    e.busy = 1'b1;
    f = k + 2 * N - 2;
    if (rel == 1) e.clr = 1'b1;
    else if (rel <= f + 1) begin
      t = rel - 2;
      e.en = t >= 1;
      for (int i = 0; i < N; i++)
        if (t >= i && t - i < k) begin
          e.av[i] = 1'b1;
          e.aa[i*AW +: AW] = AW'(t - i);
        end
      e.bv = e.av;
      e.ba = e.aa;
    end else if (rel == f + 2) e.en = 1'b1;
    else if (rel <= f + N + 2 + s) begin
      d = rel - f - 3;
      e.rv = 1'b1;
      e.row = d <= s ? '0 : RW'(d - s);
    end else e.done = 1'b1;
    return e;
  endfunction
  task automatic push_cmd(input int c0, input int k, input int s);
    for (int rel = 1; rel <= k + 3 * N + 1 + s; rel++) q.push_back('{c0 + rel, model(k, s, rel)});
  endtask
  task automatic push_err(input int c);
    snap_t e;
    e = '0;
    e.err = 1'b1;
    q.push_back('{c, e});
  endtask
  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask
  // monitor: every presented output is matched against the next expected snapshot
  always @(negedge clk) begin
    snap_t a;
    exp_t e;
    a = cur();
    if (a.done) last_done = cyc;
    if (a.busy || a.err) begin
      if (q.size() == 0) chk("unexpected_output", 64'(a), 64'(0));
      else begin
        e = q.pop_front();
        chk("output_cycle", 64'(cyc), 64'(e.cyc));
        chk("outputs", 64'(a), 64'(e.s));
      end
    end else begin
      chk("idle_outputs", 64'(a), 64'(0));
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        chk("missing_output", 64'(a), 64'(e.s));
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int c, c2;
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.result_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 64'(cur()), 64'(0));
    reset = 1'b0;
    // baseline k_len=3
    c = cyc + 1;
    wait_cyc(c);
    bus.start = 1'b1;
    bus.k_len = 3;
    push_cmd(c, 3, 0);
    wait_cyc(c + 1);
    bus.start = 1'b0;
    wait_cyc(c + 2);
    chk("enable_off_first_feed", 64'(bus.arr_enable), 64'(0));
    wait_cyc(c + 3);
    chk("enable_on_second_feed", 64'(bus.arr_enable), 64'(1));
    wait_cyc(c + 4);
    chk("row2_valid_t2", 64'(bus.a_valid[2]), 64'(1));
    chk("row2_addr_t2", 64'(bus.a_addr[2*AW +: AW]), 64'(0));
    wait_cyc(c + 6);
    chk("row2_addr_t4", 64'(bus.a_addr[2*AW +: AW]), 64'(2));
    wait_cyc(c + 7);
    chk("row2_valid_t5", 64'(bus.a_valid[2]), 64'(0));
    wait_cyc(c + 18);
    chk("done_cycle_k3", 64'(last_done - c), 64'(16));
    // rejected commands
    c = cyc + 1;
    wait_cyc(c);
    bus.start = 1'b1;
    bus.k_len = 0;
    push_err(c + 1);
    wait_cyc(c + 1);
    bus.start = 1'b0;
    wait_cyc(c + 2);
    bus.start = 1'b1;
    bus.k_len = 17;
    push_err(c + 3);
    wait_cyc(c + 3);
    bus.start = 1'b0;
    wait_cyc(c + 6);
    // k_len=16 with 5 stalled drain cycles
    c = cyc + 1;
    wait_cyc(c);
    bus.start = 1'b1;
    bus.k_len = 16;
    bus.result_ready = 1'b0;
    push_cmd(c, 16, 5);
    wait_cyc(c + 1);
    bus.start = 1'b0;
    wait_cyc(c + 30);
    bus.result_ready = 1'b1;
    wait_cyc(c + 36);
    chk("done_cycle_stall", 64'(last_done - c), 64'(34));
    // start during FEED and DONE ignored, accepted in following IDLE
    c = cyc + 1;
    wait_cyc(c);
    bus.start = 1'b1;
    bus.k_len = 3;
    push_cmd(c, 3, 0);
    wait_cyc(c + 1);
    bus.start = 1'b0;
    wait_cyc(c + 5);
    bus.start = 1'b1;
    bus.k_len = 2;
    wait_cyc(c + 6);
    bus.k_len = 0;
    wait_cyc(c + 7);
    bus.start = 1'b0;
    wait_cyc(c + 16);
    bus.start = 1'b1;
    bus.k_len = 1;
    wait_cyc(c + 17);
    push_cmd(c + 17, 1, 0);
    chk("done_cycle_ignored", 64'(last_done - c), 64'(16));
    wait_cyc(c + 18);
    bus.start = 1'b0;
    wait_cyc(c + 33);
    chk("done_cycle_after_done", 64'(last_done - c - 17), 64'(14));
    // asynchronous reset at t=4
    c = cyc + 1;
    wait_cyc(c);
    bus.start = 1'b1;
    bus.k_len = 3;
    push_cmd(c, 3, 0);
    wait_cyc(c + 1);
    bus.start = 1'b0;
    wait_cyc(c + 6);
    #2;
    reset = 1'b1;
    q.delete();
    #1;
    chk("async_reset_outputs", 64'(cur()), 64'(0));
    wait_cyc(c + 8);
    reset = 1'b0;
    c2 = c + 9;
    wait_cyc(c2);
    bus.start = 1'b1;
    bus.k_len = 1;
    push_cmd(c2, 1, 0);
    wait_cyc(c2 + 1);
    bus.start = 1'b0;
    wait_cyc(c2 + 16);
    chk("done_cycle_post_reset", 64'(last_done - c2), 64'(14));
    // back-to-back k_len=1 then K_MAX
    c = cyc + 1;
    wait_cyc(c);
    bus.start = 1'b1;
    bus.k_len = 1;
    push_cmd(c, 1, 0);
    wait_cyc(c + 1);
    bus.start = 1'b0;
    wait_cyc(c + 15);
    bus.start = 1'b1;
    bus.k_len = 16;
    push_cmd(c + 15, 16, 0);
    wait_cyc(c + 16);
    bus.start = 1'b0;
    wait_cyc(c + 46);
    chk("done_cycle_kmax", 64'(last_done - c - 15), 64'(29));
    wait_cyc(c + 49);
    chk("scoreboard_empty", 64'(q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
